s_term_cfg_loop: RTL and testbench



---
 rtl/s_term_cfg_pkg.sv | 35 +++
 rtl/clk_buf.sv | 10 +
 rtl/my_buf.sv | 10 +
 rtl/s_term_out_cell.sv | 69 ++++++
 rtl/s_term_cfg_loop.sv | 100 ++++++++++
 tb/tb_s_term_cfg_loop.sv | 183 ++++++++++++++++++
 6 files changed

// File: rtl/s_term_cfg_pkg.sv
// s_term_cfg_pkg
// Shared types and helpers for the south termination tile with configurable
// loopback.
//   mode_t           : 2-bit per-output route mode (OFF / COMB / REG / STICKY)
//   field_lsb        : bit position of output k's field in the config store
//   frame_hits_field : 1 when frame f shares at least one bit with output k's field
package s_term_cfg_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_COMB   = 2'b01,
        MODE_REG    = 2'b10,
        MODE_STICKY = 2'b11
    } mode_t;

    // Each field is sel (sel_w bits) plus a 2-bit mode.
    function automatic int field_lsb(input int k, input int sel_w);
        return k * (sel_w + 32'sd2);
    endfunction

    // Inclusive interval overlap between a frame's bit range and a field's bit range.
    function automatic logic frame_hits_field(input int f, input int k,
                                              input int sel_w, input int bits_per_row);
        int f_lo;
        int f_hi;
        int k_lo;
        int k_hi;
        f_lo = f * bits_per_row;
        f_hi = f_lo + bits_per_row - 32'sd1;
        k_lo = field_lsb(k, sel_w);
        k_hi = k_lo + sel_w + 32'sd1;
        return (f_lo <= k_hi) && (k_lo <= f_hi);
    endfunction

endpackage

// File: rtl/clk_buf.sv
// clk_buf
// Clock buffer used on the UserCLK pass-through.
//   A : clock input
//   X : buffered clock output
module clk_buf (
    input  logic A,
    output logic X
);
    assign X = A;
endmodule

// File: rtl/my_buf.sv
// my_buf
// Single-bit signal buffer used on the FrameStrobe pass-through.
//   A : input
//   X : buffered output
module my_buf (
    input  logic A,
    output logic X
);
    assign X = A;
endmodule

// File: rtl/s_term_out_cell.sv
// s_term_out_cell
// One north-going output route: picks a south END wire by sel and drives it
// out off, combinationally, registered, or as a sticky pulse catcher.
//   UserCLK       : fabric user clock
//   Reset         : asynchronous, active-high; clears the route register
//   S_in          : all south END wires
//   field         : {mode[1:0], sel[SEL_W-1:0]} from the config store
//   field_written : a frame overlapping this field is being written this cycle
//   N_out         : the north BEG wire
module s_term_out_cell
    import s_term_cfg_pkg::*;
#(
    parameter int IN_W  = 52,
    parameter int SEL_W = 6
) (
    input  logic              UserCLK,
    input  logic              Reset,
    input  logic [IN_W-1:0]   S_in,
    input  logic [SEL_W+1:0]  field,
    input  logic              field_written,
    output logic              N_out
);

    logic [SEL_W-1:0] sel_s;
    mode_t            mode_s;
    logic             src_s;
    logic             q_r;

    // Decode the field and select the source; out-of-range selects read as 0.
    always_comb begin
        sel_s  = field[SEL_W-1:0];
        mode_s = mode_t'(field[SEL_W+1:SEL_W]);
        src_s  = 1'b0;
        if ({{(32-SEL_W){1'b0}}, sel_s} < IN_W) begin
            src_s = S_in[sel_s];
        end else begin
            src_s = 1'b0;
        end
    end

    // Route register: zeroed in OFF/COMB so switching into REG/STICKY never
    // shows stale data; a write touching this field clears STICKY and beats a set.
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            q_r <= 1'b0;
        end else begin
            case (mode_s)
                MODE_OFF:    q_r <= 1'b0;
                MODE_COMB:   q_r <= 1'b0;
                MODE_REG:    q_r <= src_s;
                MODE_STICKY: q_r <= field_written ? 1'b0 : (q_r | src_s);
                default:     q_r <= 1'b0;
            endcase
        end
    end

    // Output mux; COMB is a direct path from S_in by design.
    always_comb begin
        N_out = 1'b0;
        case (mode_s)
            MODE_OFF:    N_out = 1'b0;
            MODE_COMB:   N_out = src_s;
            MODE_REG:    N_out = q_r;
            MODE_STICKY: N_out = q_r;
            default:     N_out = 1'b0;
        endcase
    end

endmodule

// File: rtl/s_term_cfg_loop.sv
// s_term_cfg_loop
// South termination tile for the fabric bottom edge with on-tile configurable
// loopback. Holds the frame-addressed config store, decodes which output
// fields are being rewritten, instantiates one route cell per output, and
// buffers FrameStrobe/UserCLK through to the next tile.
//   UserCLK       : fabric user clock
//   Reset         : asynchronous, active-high
//   FrameData     : configuration row data
//   FrameStrobe   : per-frame write strobes
//   S_in          : south END wires (S1END, S2MID, S2END, S4END, SS4END, LSB first)
//   N_out         : north BEG wires (N1BEG, N2BEG, N2BEGb, N4BEG, NN4BEG, Co, LSB first)
//   UserCLKo      : buffered UserCLK
//   FrameStrobe_O : buffered FrameStrobe
module s_term_cfg_loop
    import s_term_cfg_pkg::*;
#(
    parameter int IN_W            = 52,
    parameter int OUT_W           = 53,
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int SEL_W           = 6
) (
    input  logic                       UserCLK,
    input  logic                       Reset,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    input  logic [IN_W-1:0]            S_in,
    output logic [OUT_W-1:0]           N_out,
    output logic                       UserCLKo,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_O
);

    localparam int FIELD_W = SEL_W + 2;
    localparam int CFG_W   = MaxFramesPerCol * FrameBitsPerRow;

    if (OUT_W * FIELD_W > CFG_W) begin : g_err_cfg_size
        $error("s_term_cfg_loop: OUT_W*(SEL_W+2) exceeds config store size");
    end
    if ((1 << SEL_W) < IN_W) begin : g_err_sel_width
        $error("s_term_cfg_loop: SEL_W too narrow to address IN_W inputs");
    end

    logic [CFG_W-1:0] cfg_r;
    logic [OUT_W-1:0] field_written_s;
    // Bits past the last field are stored but drive nothing.
    logic             unused_cfg_s;

    assign unused_cfg_s = ^cfg_r;

    // Config store: every strobed frame takes FrameData; reset drops any write in flight.
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            cfg_r <= '0;
        end else begin
            for (int f = 0; f < MaxFramesPerCol; f++) begin
                if (FrameStrobe[f]) begin
                    cfg_r[f*FrameBitsPerRow +: FrameBitsPerRow] <= FrameData;
                end
            end
        end
    end

    // Per-output "field being rewritten" flag; frame/field overlap is constant per (f,k).
    always_comb begin
        field_written_s = '0;
        for (int k = 0; k < OUT_W; k++) begin
            for (int f = 0; f < MaxFramesPerCol; f++) begin
                field_written_s[k] = field_written_s[k]
                                   | (FrameStrobe[f] & frame_hits_field(f, k, SEL_W, FrameBitsPerRow));
            end
        end
    end

    for (genvar k = 0; k < OUT_W; k++) begin : g_cell
        s_term_out_cell #(
            .IN_W  (IN_W),
            .SEL_W (SEL_W)
        ) u_cell (
            .UserCLK       (UserCLK),
            .Reset         (Reset),
            .S_in          (S_in),
            .field         (cfg_r[field_lsb(k, SEL_W) +: FIELD_W]),
            .field_written (field_written_s[k]),
            .N_out         (N_out[k])
        );
    end

    clk_buf u_clk_buf (
        .A (UserCLK),
        .X (UserCLKo)
    );

    for (genvar f = 0; f < MaxFramesPerCol; f++) begin : g_strobe_buf
        my_buf u_strobe_buf (
            .A (FrameStrobe[f]),
            .X (FrameStrobe_O[f])
        );
    end

endmodule

// File: tb/tb_s_term_cfg_loop.sv
// Directed bench for s_term_cfg_loop with default parameters.
// Inputs change on the falling edge of UserCLK; outputs are sampled away from
// the rising edge. Field width is 8 bits, so output k sits in frame k/4.
module tb_s_term_cfg_loop;

    logic          UserCLK;
    logic          Reset;
    logic [31:0]   FrameData;
    logic [19:0]   FrameStrobe;
    logic [51:0]   S_in;
    logic [52:0]   N_out;
    logic          UserCLKo;
    logic [19:0]   FrameStrobe_O;

    int n_assert;
    int n_fail;

    s_term_cfg_loop dut (
        .UserCLK       (UserCLK),
        .Reset         (Reset),
        .FrameData     (FrameData),
        .FrameStrobe   (FrameStrobe),
        .S_in          (S_in),
        .N_out         (N_out),
        .UserCLKo      (UserCLKo),
        .FrameStrobe_O (FrameStrobe_O)
    );

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one write for exactly one rising edge, then drop the strobes.
    task automatic write_frame(input logic [19:0] mask, input logic [31:0] data);
        @(negedge UserCLK);
        FrameStrobe = mask;
        FrameData   = data;
        @(negedge UserCLK);
        FrameStrobe = 20'h0;
        FrameData   = 32'h0;
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        Reset       = 1'b1;
        S_in        = '1;
        FrameStrobe = 20'h0;
        FrameData   = 32'h0;

        // Reset state, pass-throughs
        #12;
        check("rst_nout", 64'(N_out), 64'h0);
        FrameStrobe = 20'hA5A5A;
        FrameData   = 32'hFFFF_FFFF;
        #1;
        check("strobe_o", 64'(FrameStrobe_O), 64'hA5A5A);
        check("clko_low", 64'(UserCLKo), 64'h0);
        @(posedge UserCLK);
        #1;
        check("clko_high", 64'(UserCLKo), 64'h1);
        check("rst_hold_nout", 64'(N_out), 64'h0);
        FrameStrobe = 20'h0;
        FrameData   = 32'h0;
        @(negedge UserCLK);
        Reset = 1'b0;
        #1;
        check("post_rst_nout", 64'(N_out), 64'h0);
        @(negedge UserCLK);
        check("post_rst_nout2", 64'(N_out), 64'h0);

        // Output 0 COMB, sel=3
        write_frame(20'h1, 32'h0000_0043);
        S_in = '0;
        #1;
        check("comb_low", 64'(N_out), 64'h0);
        S_in = 52'h8;
        #1;
        check("comb_high", 64'(N_out), 64'h1);
        S_in = '1;
        #1;
        check("comb_others_off", 64'(N_out), 64'h1);
        S_in = 52'h0;
        #1;
        check("comb_back_low", 64'(N_out), 64'h0);

        // Output 0 REG, sel=3
        write_frame(20'h1, 32'h0000_0083);
        check("reg_init", 64'(N_out), 64'h0);
        S_in = 52'h8;
        #1;
        check("reg_not_comb", 64'(N_out), 64'h0);
        @(negedge UserCLK);
        check("reg_lat1", 64'(N_out), 64'h1);
        S_in = 52'h0;
        @(negedge UserCLK);
        check("reg_one_cycle", 64'(N_out), 64'h0);

        // Output 0 STICKY, sel=5
        write_frame(20'h1, 32'h0000_00C5);
        check("stk_init", 64'(N_out), 64'h0);
        S_in = 52'h20;
        @(negedge UserCLK);
        S_in = 52'h0;
        check("stk_set", 64'(N_out), 64'h1);
        @(negedge UserCLK);
        check("stk_hold", 64'(N_out), 64'h1);
        write_frame(20'h1, 32'h0000_00C5);
        check("stk_clear", 64'(N_out), 64'h0);
        @(negedge UserCLK);
        S_in        = 52'h20;
        FrameStrobe = 20'h1;
        FrameData   = 32'h0000_00C5;
        @(negedge UserCLK);
        FrameStrobe = 20'h0;
        FrameData   = 32'h0;
        S_in        = 52'h0;
        check("stk_clear_wins", 64'(N_out), 64'h0);
        @(negedge UserCLK);
        check("stk_clear_wins2", 64'(N_out), 64'h0);
        S_in = 52'h20;
        @(negedge UserCLK);
        S_in = 52'h0;
        check("stk_reset", 64'(N_out), 64'h1);
        write_frame(20'h4, 32'h0);
        check("stk_other_frame", 64'(N_out), 64'h1);

        // Frames 1 and 2 together: COMB sel=1 on outputs 4..11, then STICKY sel=63
        write_frame(20'h6, 32'h4141_4141);
        S_in = 52'h2;
        #1;
        check("multi_comb", 64'(N_out), 64'hFF1);
        write_frame(20'h6, 32'hFFFF_FFFF);
        S_in = '1;
        #1;
        check("multi_sel63", 64'(N_out), 64'h1);
        @(negedge UserCLK);
        check("multi_sel63_2", 64'(N_out), 64'h1);
        @(negedge UserCLK);
        check("multi_sel63_3", 64'(N_out), 64'h1);

        // Output 52 (Co) COMB, sel=51 (frame 13, bits [7:0])
        write_frame(20'h02000, 32'h0000_0073);
        S_in = 52'h0;
        #1;
        check("co_low", 64'(N_out), 64'h1);
        S_in = 52'h8_0000_0000_0000;
        #1;
        check("co_high", 64'(N_out), 64'h0010_0000_0000_0001);

        // Reset mid-operation, with a write pending during reset
        Reset = 1'b1;
        #1;
        check("mid_rst_nout", 64'(N_out), 64'h0);
        FrameStrobe = 20'h1;
        FrameData   = 32'h0000_0043;
        S_in        = '1;
        #1;
        check("mid_rst_strobe_o", 64'(FrameStrobe_O), 64'h1);
        @(posedge UserCLK);
        #1;
        check("mid_rst_edge", 64'(N_out), 64'h0);
        @(negedge UserCLK);
        Reset       = 1'b0;
        FrameStrobe = 20'h0;
        FrameData   = 32'h0;
        #1;
        check("rel_nout", 64'(N_out), 64'h0);
        @(negedge UserCLK);
        check("rel_nout2", 64'(N_out), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
